// File: rtl/axis_bram_writer_if.sv
// rtl/axis_bram_writer_if.sv - stream ingress and BRAM write port bundle for axis_bram_writer
interface axis_bram_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tstrb;
  logic                s_axis_tlast;

  logic [ADDR_W-1:0]   bram_addr;
  logic [DATA_W-1:0]   bram_din;
  logic [DATA_W/8-1:0] bram_we;
  logic                bram_en;
  logic [DATA_W-1:0]   bram_dout;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tstrb, s_axis_tlast, bram_dout,
    input  s_axis_tready, bram_addr, bram_din, bram_we, bram_en
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tstrb, s_axis_tlast, bram_dout,
    output s_axis_tready, bram_addr, bram_din, bram_we, bram_en
  );
endinterface

// File: rtl/axis_bram_writer.sv
// rtl/axis_bram_writer.sv - AXI4-Stream slave writing accepted beats to consecutive BRAM addresses
module axis_bram_writer #(
  parameter int C_AXIS_BRAM_ADDR_WIDTH = 12,
  parameter int C_AXIS_BRAM_DATA_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ctrl_w_start,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_w_start_index,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_w_length,
  output logic                              ctrl_w_busy,
  output logic                              ctrl_w_done,
  output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0] ctrl_w_count,
  output logic                              ctrl_w_early,
  output logic                              bram_clk,
  axis_bram_writer_if.slave                 bus
);
  localparam int AW = C_AXIS_BRAM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   len;
  logic [AW-1:0]   cnt_inc;
  logic            hs;
  logic            last_beat;
  logic            unused_dout;

  assign bram_clk          = clk;
  assign unused_dout       = ^bus.bram_dout;
  assign bus.s_axis_tready = (state == RUN);
  assign ctrl_w_busy       = (state != IDLE);
  assign ctrl_w_done       = (state == DONE);

  // Count never exceeds length-1 before the final beat, so the increment cannot wrap.
  assign cnt_inc   = ctrl_w_count + AW'(1);
  assign hs        = bus.s_axis_tvalid & bus.s_axis_tready;
  assign last_beat = hs & ((cnt_inc == len) | bus.s_axis_tlast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_w_start) begin
          state_nxt = (ctrl_w_length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      len           <= '0;
      ctrl_w_count  <= '0;
      ctrl_w_early  <= 1'b0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
    end else begin
      bus.bram_en <= hs;
      if (state == IDLE && ctrl_w_start) begin
        ptr          <= ctrl_w_start_index;
        len          <= ctrl_w_length;
        ctrl_w_count <= '0;
        ctrl_w_early <= 1'b0;
      end
      // Address and data hold between writes; only the enables fall back to zero.
      if (hs) begin
        bus.bram_addr <= ptr;
        bus.bram_din  <= bus.s_axis_tdata;
        bus.bram_we   <= bus.s_axis_tstrb;
        ptr           <= ptr + AW'(1);
        ctrl_w_count  <= cnt_inc;
        ctrl_w_early  <= bus.s_axis_tlast & (cnt_inc < len);
      end else begin
        bus.bram_we   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axis_bram_writer.sv
// tb/tb_axis_bram_writer.sv - randomized self-checking bench for axis_bram_writer
module tb_axis_bram_writer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_w_start;
  logic [11:0] ctrl_w_start_index;
  logic [11:0] ctrl_w_length;
  logic        ctrl_w_busy;
  logic        ctrl_w_done;
  logic [11:0] ctrl_w_count;
  logic        ctrl_w_early;
  logic        bram_clk;
  int          checks = 0;
  int          failures = 0;

  axis_bram_writer_if #(.ADDR_W(12), .DATA_W(64)) bus ();

  axis_bram_writer #(
    .C_AXIS_BRAM_ADDR_WIDTH(12),
    .C_AXIS_BRAM_DATA_WIDTH(64)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ctrl_w_start       (ctrl_w_start),
    .ctrl_w_start_index (ctrl_w_start_index),
    .ctrl_w_length      (ctrl_w_length),
    .ctrl_w_busy        (ctrl_w_busy),
    .ctrl_w_done        (ctrl_w_done),
    .ctrl_w_count       (ctrl_w_count),
    .ctrl_w_early       (ctrl_w_early),
    .bram_clk           (bram_clk),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  // One transfer: the model is "accepted beats = first min(length, tlast position) beats,
  // written in order to (index + k) mod 4096"; the extra presented beat must stay unaccepted.
  task automatic do_xfer(input logic [11:0] idx, input logic [11:0] len, input int tlast_at,
                         input bit toggle, input int strb_beat, input bit extra_start);
    logic [63:0] d[$];
    logic [7:0]  s[$];
    bit          l[$];
    int          n_exp, nb, bi, nw;
    bit          exp_early, seen_done, hs;
    logic [11:0] exp_addr;
    n_exp = int'(len);
    if (tlast_at > 0 && tlast_at < n_exp) n_exp = tlast_at;
    exp_early = (tlast_at > 0) && (tlast_at < int'(len));
    nb = n_exp + 1;
    for (int k = 0; k < nb; k++) begin
      d.push_back({$urandom, $urandom});
      s.push_back((k + 1 == strb_beat) ? 8'h0F : 8'hFF);
      l.push_back(k + 1 == tlast_at);
    end
    @(posedge clk); #1;
    ctrl_w_start = 1'b1; ctrl_w_start_index = idx; ctrl_w_length = len;
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = d[0]; bus.s_axis_tstrb = s[0]; bus.s_axis_tlast = l[0];
    @(posedge clk); #1;
    ctrl_w_start = 1'b0;
    checks++;
    if (ctrl_w_busy !== 1'b1 || bus.s_axis_tready !== (len != 0)) begin
      failures++;
      $display("FAIL start_latency busy=%b tready=%b required busy=1 tready=%b", ctrl_w_busy, bus.s_axis_tready, len != 0);
    end
    bi = 0; nw = 0; seen_done = 0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      bus.s_axis_tvalid = (bi < nb) && (!toggle || (c % 2 == 0));
      if (bi < nb) begin
        bus.s_axis_tdata = d[bi]; bus.s_axis_tstrb = s[bi]; bus.s_axis_tlast = l[bi];
      end
      ctrl_w_start = extra_start && (bi == 2);
      ctrl_w_start_index = idx + 12'd100;
      @(negedge clk);
      if (bus.bram_en === 1'b1) begin
        checks++;
        exp_addr = 12'((int'(idx) + nw) % 4096);
        if (nw >= n_exp) begin
          failures++;
          $display("FAIL extra_write addr=%h write#=%0d required only %0d writes", bus.bram_addr, nw + 1, n_exp);
        end else if (bus.bram_addr !== exp_addr || bus.bram_din !== d[nw] || bus.bram_we !== s[nw]) begin
          failures++;
          $display("FAIL write%0d addr=%h din=%h we=%h required addr=%h din=%h we=%h",
                   nw, bus.bram_addr, bus.bram_din, bus.bram_we, exp_addr, d[nw], s[nw]);
        end
        nw++;
      end
      if (ctrl_w_busy && !ctrl_w_done) begin
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin
          failures++;
          $display("FAIL run_tready tready=%b required 1", bus.s_axis_tready);
        end
      end
      checks++;
      if (ctrl_w_count !== 12'(bi)) begin
        failures++;
        $display("FAIL running_count count=%0d required %0d", ctrl_w_count, bi);
      end
      if (ctrl_w_done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (bus.bram_en !== (n_exp > 0) || ctrl_w_count !== 12'(n_exp) || ctrl_w_early !== exp_early ||
            bus.s_axis_tready !== 1'b0) begin
          failures++;
          $display("FAIL done_cycle en=%b count=%0d early=%b tready=%b required en=%b count=%0d early=%b tready=0",
                   bus.bram_en, ctrl_w_count, ctrl_w_early, bus.s_axis_tready, n_exp > 0, n_exp, exp_early);
        end
      end
      hs = bus.s_axis_tvalid && bus.s_axis_tready;
      @(posedge clk); #1;
      if (hs) bi++;
    end
    ctrl_w_start = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL done_timeout done pulse not seen required within 200 cycles");
    end
    for (int c = 0; c < 3; c++) begin
      bus.s_axis_tvalid = (bi < nb);
      @(negedge clk);
      checks++;
      if (bus.s_axis_tready !== 1'b0 || bus.bram_en !== 1'b0 || ctrl_w_busy !== 1'b0 ||
          ctrl_w_done !== 1'b0 || ctrl_w_count !== 12'(n_exp) || ctrl_w_early !== exp_early) begin
        failures++;
        $display("FAIL after_done tready=%b en=%b busy=%b done=%b count=%0d early=%b required 0 0 0 0 %0d %b",
                 bus.s_axis_tready, bus.bram_en, ctrl_w_busy, ctrl_w_done, ctrl_w_count, ctrl_w_early, n_exp, exp_early);
      end
      @(posedge clk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    checks++;
    if (nw != n_exp || bi != n_exp) begin
      failures++;
      $display("FAIL beat_totals writes=%0d accepted=%0d required %0d", nw, bi, n_exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.s_axis_tready !== 1'b0 || bus.bram_en !== 1'b0 || bus.bram_we !== 8'h00 || bus.bram_addr !== 12'h000 ||
        bus.bram_din !== 64'h0 || ctrl_w_busy !== 1'b0 || ctrl_w_done !== 1'b0 || ctrl_w_count !== 12'h000 ||
        ctrl_w_early !== 1'b0) begin
      failures++;
      $display("FAIL reset_values tready=%b en=%b we=%h addr=%h din=%h busy=%b done=%b count=%h early=%b required all 0",
               bus.s_axis_tready, bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_din, ctrl_w_busy, ctrl_w_done,
               ctrl_w_count, ctrl_w_early);
    end
    checks++;
    if (bram_clk !== clk) begin
      failures++;
      $display("FAIL bram_clk bram_clk=%b required %b", bram_clk, clk);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();        do_xfer(12'h010, 12'd4, 4, 0, 0, 0); endtask
  task automatic test_wrap();         do_xfer(12'hFFE, 12'd4, 0, 0, 0, 0); endtask
  task automatic test_early_tlast();  do_xfer(12'h200, 12'd8, 3, 0, 0, 0); endtask
  task automatic test_toggle_strb();  do_xfer(12'h080, 12'd5, 0, 1, 2, 1); endtask
  task automatic test_zero_length();  do_xfer(12'h123, 12'd0, 0, 0, 0, 0); endtask

  task automatic test_reset_mid();
    int bi;
    bit hs;
    @(posedge clk); #1;
    ctrl_w_start = 1'b1; ctrl_w_start_index = 12'h300; ctrl_w_length = 12'd6;
    @(posedge clk); #1;
    ctrl_w_start = 1'b0;
    bi = 0;
    for (int c = 0; c < 20 && bi < 2; c++) begin
      bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = {$urandom, $urandom};
      bus.s_axis_tstrb = 8'hFF; bus.s_axis_tlast = 1'b0;
      @(negedge clk);
      hs = bus.s_axis_tready;
      @(posedge clk); #1;
      if (hs) bi++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.s_axis_tready !== 1'b0 || bus.bram_en !== 1'b0 || bus.bram_we !== 8'h00 || ctrl_w_busy !== 1'b0 ||
        ctrl_w_count !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid tready=%b en=%b we=%h busy=%b count=%0d required all 0",
               bus.s_axis_tready, bus.bram_en, bus.bram_we, ctrl_w_busy, ctrl_w_count);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (ctrl_w_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done done=%b required 0", ctrl_w_done);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    do_xfer(12'h345, 12'd3, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      do_xfer(12'($urandom_range(0, 4095)), 12'($urandom_range(1, 12)), int'($urandom_range(0, 14)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    do_xfer(12'hFFF, 12'd2, 0, 0, 0, 0);
    do_xfer(12'h000, 12'd1, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    ctrl_w_start = 1'b0;
    ctrl_w_start_index = '0;
    ctrl_w_length = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tstrb = '0;
    bus.s_axis_tlast = 1'b0;
    bus.bram_dout = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_early_tlast();
    test_toggle_strb();
    test_zero_length();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
